// File: rtl/rf_pkg.sv
// rf_pkg
//   Shared definitions for the register-file write-port scheduler:
//   default sizes, address/data/write-record types and the grant encoding
//   used to name the winning requester of the single write port.
package rf_pkg;

  localparam int RF_ADDRESS_WIDTH  = 5;
  localparam int RF_DATA_WIDTH     = 32;
  localparam int RF_LSU_FIFO_DEPTH = 2;
  localparam int RF_STARVE_LIMIT   = 4;

  typedef logic [RF_ADDRESS_WIDTH-1:0] rf_addr_t;
  typedef logic [RF_DATA_WIDTH-1:0]    rf_data_t;

  typedef struct packed {
    rf_addr_t rd;
    rf_data_t data;
  } rf_wr_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WB   = 2'd1,
    GNT_LSU  = 2'd2,
    GNT_DBG  = 2'd3
  } grant_e;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
//   Single-clock FIFO used to buffer late LSU results until the register
//   file write port is free. DEPTH must be a power of two >= 2; the
//   pointers carry one extra wrap bit so full and empty are distinguished
//   without a separate counter.
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset (empties the FIFO)
//   push       write push_data (ignored when full)
//   push_data  entry to enqueue
//   pop        drop the head entry (ignored when empty)
//   head_data  current head entry (valid when !empty)
//   empty      no entries stored
//   full       DEPTH entries stored
module sync_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  // Same slot index but opposite wrap bits: writer is a full lap ahead.
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign head_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/rf_write_sched.sv
// rf_write_sched
//   Shares the single write port (A3/WE3/WD3) of the integer register file
//   between pipeline writeback (never stalled), buffered LSU late results
//   and a debug write port, and tracks which registers have a load in
//   flight so the hazard logic can stall their readers.
// Ports:
//   CLK, RSTn                      clock, async active-low reset
//   WB_VALID/WB_RD/WB_DATA         pipeline writeback, always granted
//   ISSUE_VALID/ISSUE_RD           load issued this cycle (marks rd busy)
//   LSU_VALID/LSU_READY/LSU_RD/LSU_DATA  LSU result handshake into FIFO
//   DBG_VALID/DBG_READY/DBG_RD/DBG_DATA  debug write, READY = granted now
//   RS1, RS2 / BUSY_RS1, BUSY_RS2  pending-load queries
//   A3, WE3, WD3                   register file write port (combinational)
module rf_write_sched
  import rf_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = RF_ADDRESS_WIDTH,
  parameter int DATA_WIDTH     = RF_DATA_WIDTH,
  parameter int LSU_FIFO_DEPTH = RF_LSU_FIFO_DEPTH,
  parameter int STARVE_LIMIT   = RF_STARVE_LIMIT
) (
  input  logic                     CLK,
  input  logic                     RSTn,
  input  logic                     WB_VALID,
  input  logic [ADDRESS_WIDTH-1:0] WB_RD,
  input  logic [DATA_WIDTH-1:0]    WB_DATA,
  input  logic                     ISSUE_VALID,
  input  logic [ADDRESS_WIDTH-1:0] ISSUE_RD,
  input  logic                     LSU_VALID,
  output logic                     LSU_READY,
  input  logic [ADDRESS_WIDTH-1:0] LSU_RD,
  input  logic [DATA_WIDTH-1:0]    LSU_DATA,
  input  logic                     DBG_VALID,
  output logic                     DBG_READY,
  input  logic [ADDRESS_WIDTH-1:0] DBG_RD,
  input  logic [DATA_WIDTH-1:0]    DBG_DATA,
  input  logic [ADDRESS_WIDTH-1:0] RS1,
  input  logic [ADDRESS_WIDTH-1:0] RS2,
  output logic                     BUSY_RS1,
  output logic                     BUSY_RS2,
  output logic [ADDRESS_WIDTH-1:0] A3,
  output logic                     WE3,
  output logic [DATA_WIDTH-1:0]    WD3
);

  localparam int NREG = 2 ** ADDRESS_WIDTH;
  localparam int FW   = ADDRESS_WIDTH + DATA_WIDTH;
  localparam int CW   = $clog2(STARVE_LIMIT + 1);

  logic                     fifo_push;
  logic                     fifo_pop;
  logic                     fifo_empty;
  logic                     fifo_full;
  logic [FW-1:0]            fifo_head;
  logic [ADDRESS_WIDTH-1:0] head_rd;
  logic [DATA_WIDTH-1:0]    head_data;

  logic [CW-1:0]            starve_cnt_q, starve_cnt_d;
  logic                     starved;
  logic [NREG-1:0]          busy_q, busy_d;

  grant_e                   gnt;
  logic [ADDRESS_WIDTH-1:0] win_rd;
  logic [DATA_WIDTH-1:0]    win_data;

  // ------------------------------------------------------------------
  // LSU result buffer
  // ------------------------------------------------------------------
  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (LSU_FIFO_DEPTH)
  ) u_lsu_fifo (
    .clk       (CLK),
    .rst_n     (RSTn),
    .push      (fifo_push),
    .push_data ({LSU_RD, LSU_DATA}),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign {head_rd, head_data} = fifo_head;

  // Ready looks only at full, never at a same-cycle pop, so it carries no
  // combinational path from the arbitration back to the LSU.
  assign LSU_READY = RSTn && !fifo_full;
  assign fifo_push = LSU_VALID && LSU_READY;
  assign fifo_pop  = (gnt == GNT_LSU);

  // ------------------------------------------------------------------
  // Arbitration
  // ------------------------------------------------------------------
  assign starved = (starve_cnt_q == CW'(STARVE_LIMIT));

  always_comb begin
    gnt = GNT_NONE;
    if (!RSTn)                     gnt = GNT_NONE;
    else if (WB_VALID)             gnt = GNT_WB;
    else if (starved && DBG_VALID) gnt = GNT_DBG;
    else if (!fifo_empty)          gnt = GNT_LSU;
    else if (DBG_VALID)            gnt = GNT_DBG;
  end

  always_comb begin
    win_rd   = '0;
    win_data = '0;
    case (gnt)
      GNT_WB: begin
        win_rd   = WB_RD;
        win_data = WB_DATA;
      end
      GNT_LSU: begin
        win_rd   = head_rd;
        win_data = head_data;
      end
      GNT_DBG: begin
        win_rd   = DBG_RD;
        win_data = DBG_DATA;
      end
      default: begin
        win_rd   = '0;
        win_data = '0;
      end
    endcase
  end

  // x0 is hardwired: the winner still consumes its grant, only the
  // register file strobe is withheld.
  assign A3        = win_rd;
  assign WD3       = win_data;
  assign WE3       = (gnt != GNT_NONE) && (win_rd != '0);
  assign DBG_READY = (gnt == GNT_DBG);

  // ------------------------------------------------------------------
  // DBG starvation counter
  // ------------------------------------------------------------------
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!DBG_VALID || DBG_READY) starve_cnt_d = '0;
    else if (!starved)           starve_cnt_d = starve_cnt_q + CW'(1);
  end

  // ------------------------------------------------------------------
  // Pending-load scoreboard
  // ------------------------------------------------------------------
  always_comb begin
    busy_d = busy_q;
    if (fifo_pop) busy_d[head_rd] = 1'b0;
    // Applied after the clear: a load issued to the register being
    // committed is a new outstanding load and must stay visible.
    if (ISSUE_VALID && (ISSUE_RD != '0)) busy_d[ISSUE_RD] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      starve_cnt_q <= '0;
      busy_q       <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      busy_q       <= busy_d;
    end
  end

  // Not bypassed: a commit's clear is seen by readers one cycle later.
  assign BUSY_RS1 = busy_q[RS1];
  assign BUSY_RS2 = busy_q[RS2];

endmodule

// File: tb/tb_rf_write_sched.sv
module tb_rf_write_sched;
  import rf_pkg::*;

  localparam int AW = RF_ADDRESS_WIDTH;
  localparam int DW = RF_DATA_WIDTH;

  logic          CLK = 1'b0;
  logic          RSTn = 1'b0;
  logic          WB_VALID = 1'b0;
  logic [AW-1:0] WB_RD = '0;
  logic [DW-1:0] WB_DATA = '0;
  logic          ISSUE_VALID = 1'b0;
  logic [AW-1:0] ISSUE_RD = '0;
  logic          LSU_VALID = 1'b0;
  logic          LSU_READY;
  logic [AW-1:0] LSU_RD = '0;
  logic [DW-1:0] LSU_DATA = '0;
  logic          DBG_VALID = 1'b0;
  logic          DBG_READY;
  logic [AW-1:0] DBG_RD = '0;
  logic [DW-1:0] DBG_DATA = '0;
  logic [AW-1:0] RS1 = '0;
  logic [AW-1:0] RS2 = '0;
  logic          BUSY_RS1, BUSY_RS2;
  logic [AW-1:0] A3;
  logic          WE3;
  logic [DW-1:0] WD3;

  rf_write_sched dut (
    .CLK(CLK), .RSTn(RSTn),
    .WB_VALID(WB_VALID), .WB_RD(WB_RD), .WB_DATA(WB_DATA),
    .ISSUE_VALID(ISSUE_VALID), .ISSUE_RD(ISSUE_RD),
    .LSU_VALID(LSU_VALID), .LSU_READY(LSU_READY), .LSU_RD(LSU_RD), .LSU_DATA(LSU_DATA),
    .DBG_VALID(DBG_VALID), .DBG_READY(DBG_READY), .DBG_RD(DBG_RD), .DBG_DATA(DBG_DATA),
    .RS1(RS1), .RS2(RS2), .BUSY_RS1(BUSY_RS1), .BUSY_RS2(BUSY_RS2),
    .A3(A3), .WE3(WE3), .WD3(WD3)
  );

  always #5 CLK = ~CLK;

  int     n_checks = 0;
  int     n_errors = 0;
  rf_wr_t exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    WB_VALID = 1'b0; ISSUE_VALID = 1'b0; LSU_VALID = 1'b0; DBG_VALID = 1'b0;
  endtask

  // Write-port monitor: WB writes are checked against the WB inputs; other
  // writes outside a DBG grant must be LSU results, in acceptance order.
  always @(negedge CLK) begin
    if (RSTn) begin
      if (WB_VALID) begin
        check_eq("wb_a3", A3, WB_RD);
        check_eq("wb_wd3", WD3, WB_DATA);
        check_eq("wb_we3", WE3, (WB_RD != '0));
      end else if (WE3 && !DBG_READY) begin
        if (exp_q.size() == 0) begin
          check_eq("lsu_spurious_write", WE3, 1'b0);
        end else begin
          rf_wr_t e;
          e = exp_q.pop_front();
          check_eq("lsu_commit_a3", A3, e.rd);
          check_eq("lsu_commit_wd3", WD3, e.data);
        end
      end
    end
  end

  initial begin
    bit lsu_acc;
    int lsu_idx;

    // ---------------- reset, requests held during reset ----------------
    WB_VALID = 1'b1; WB_RD = 5'd3; WB_DATA = 32'h1234_5678;
    DBG_VALID = 1'b1; DBG_RD = 5'd4;
    @(negedge CLK);
    check_eq("rst_we3", WE3, 1'b0);
    check_eq("rst_a3", A3, '0);
    check_eq("rst_wd3", WD3, '0);
    check_eq("rst_lsu_ready", LSU_READY, 1'b0);
    check_eq("rst_dbg_ready", DBG_READY, 1'b0);
    idle_inputs();
    tick(); RSTn = 1'b1;
    tick();
    @(negedge CLK);
    check_eq("idle_lsu_ready", LSU_READY, 1'b1);
    check_eq("idle_we3", WE3, 1'b0);
    for (int r = 0; r < 32; r++) begin
      RS1 = AW'(r); RS2 = AW'(31 - r);
      @(negedge CLK);
      check_eq("idle_busy_rs1", BUSY_RS1, 1'b0);
      check_eq("idle_busy_rs2", BUSY_RS2, 1'b0);
    end

    // ---------------- load issue / LSU commit / busy clear ----------------
    tick(); ISSUE_VALID = 1'b1; ISSUE_RD = 5'd5; RS1 = 5'd5; RS2 = 5'd6;
    @(negedge CLK);
    check_eq("busy_not_bypassed_issue", BUSY_RS1, 1'b0);
    tick(); ISSUE_VALID = 1'b0;
    LSU_VALID = 1'b1; LSU_RD = 5'd5; LSU_DATA = 32'hDEAD_BEEF;
    exp_q.push_back('{rd: 5'd5, data: 32'hDEAD_BEEF});
    @(negedge CLK);
    check_eq("busy5_after_issue", BUSY_RS1, 1'b1);
    check_eq("busy6_untouched", BUSY_RS2, 1'b0);
    check_eq("lsu_ready_empty", LSU_READY, 1'b1);
    check_eq("no_write_on_enqueue", WE3, 1'b0);
    tick(); LSU_VALID = 1'b0;
    @(negedge CLK);
    check_eq("lsu5_a3", A3, 5'd5);
    check_eq("lsu5_wd3", WD3, 32'hDEAD_BEEF);
    check_eq("lsu5_we3", WE3, 1'b1);
    check_eq("busy5_commit_cycle", BUSY_RS1, 1'b1);
    tick();
    @(negedge CLK);
    check_eq("busy5_cleared", BUSY_RS1, 1'b0);
    check_eq("idle_after_commit_we3", WE3, 1'b0);

    // ---------------- WB blocks the port, FIFO fills ----------------
    tick(); WB_VALID = 1'b1; WB_RD = 5'd1; WB_DATA = 32'h1000;
    LSU_VALID = 1'b1; LSU_RD = 5'd11; LSU_DATA = 32'hA0;
    @(negedge CLK);
    check_eq("fill_ready0", LSU_READY, 1'b1);
    exp_q.push_back('{rd: 5'd11, data: 32'hA0});
    tick(); WB_RD = 5'd2; WB_DATA = 32'h1001; LSU_RD = 5'd12; LSU_DATA = 32'hA1;
    @(negedge CLK);
    check_eq("fill_ready1", LSU_READY, 1'b1);
    exp_q.push_back('{rd: 5'd12, data: 32'hA1});
    tick(); WB_RD = 5'd3; WB_DATA = 32'h1002; LSU_RD = 5'd13; LSU_DATA = 32'hA2;
    @(negedge CLK);
    check_eq("full_ready_third", LSU_READY, 1'b0);
    tick(); WB_RD = 5'd4; WB_DATA = 32'h1003;
    @(negedge CLK);
    check_eq("full_ready_wb4", LSU_READY, 1'b0);
    tick(); WB_VALID = 1'b0;
    @(negedge CLK);
    check_eq("full_ready_while_pop", LSU_READY, 1'b0);
    check_eq("drain0_a3", A3, 5'd11);
    check_eq("drain0_we3", WE3, 1'b1);
    tick();
    @(negedge CLK);
    check_eq("drain_ready_after_pop", LSU_READY, 1'b1);
    check_eq("drain1_a3", A3, 5'd12);
    exp_q.push_back('{rd: 5'd13, data: 32'hA2});
    tick(); LSU_VALID = 1'b0;
    @(negedge CLK);
    check_eq("drain2_a3", A3, 5'd13);
    check_eq("drain2_wd3", WD3, 32'hA2);
    tick();
    @(negedge CLK);
    check_eq("drain_idle_we3", WE3, 1'b0);
    check_eq("q_drained_fill", exp_q.size(), 0);

    // ---------------- DBG starvation under continuous LSU traffic ----------------
    lsu_idx = 0;
    tick(); LSU_VALID = 1'b1; LSU_RD = 5'd20; LSU_DATA = 32'h5000;
    @(negedge CLK);
    lsu_acc = LSU_READY;
    if (lsu_acc) exp_q.push_back('{rd: LSU_RD, data: LSU_DATA});
    for (int c = 0; c < 10; c++) begin
      tick();
      if (lsu_acc) begin
        lsu_idx++;
        LSU_RD = AW'(20 + (lsu_idx % 8));
        LSU_DATA = 32'h5000 + 32'(lsu_idx);
      end
      DBG_VALID = 1'b1;
      if (c < 5) begin DBG_RD = 5'd10; DBG_DATA = 32'hDB0A; end
      else       begin DBG_RD = 5'd12; DBG_DATA = 32'hDB0C; end
      @(negedge CLK);
      check_eq("dbg_ready_timing", DBG_READY, (c == 4 || c == 9));
      if (c == 4) begin
        check_eq("dbg10_a3", A3, 5'd10);
        check_eq("dbg10_wd3", WD3, 32'hDB0A);
        check_eq("dbg10_we3", WE3, 1'b1);
      end
      if (c == 9) check_eq("dbg12_a3", A3, 5'd12);
      lsu_acc = LSU_READY;
      if (lsu_acc) exp_q.push_back('{rd: LSU_RD, data: LSU_DATA});
    end
    tick(); LSU_VALID = 1'b0; DBG_VALID = 1'b0;
    repeat (4) tick();
    @(negedge CLK);
    check_eq("q_drained_starve", exp_q.size(), 0);

    // ---------------- x0 suppression ----------------
    tick(); LSU_VALID = 1'b1; LSU_RD = 5'd0; LSU_DATA = 32'h0BAD_0000;
    @(negedge CLK);
    check_eq("x0_lsu_ready", LSU_READY, 1'b1);
    tick(); LSU_VALID = 1'b0;
    @(negedge CLK);
    check_eq("x0_lsu_we3", WE3, 1'b0);
    check_eq("x0_lsu_a3", A3, 5'd0);
    check_eq("x0_lsu_wd3", WD3, 32'h0BAD_0000);
    tick(); LSU_VALID = 1'b1; LSU_RD = 5'd3; LSU_DATA = 32'h33;
    exp_q.push_back('{rd: 5'd3, data: 32'h33});
    tick(); LSU_VALID = 1'b0;
    @(negedge CLK);
    check_eq("x0_popped_next_a3", A3, 5'd3);
    check_eq("x0_popped_next_we3", WE3, 1'b1);
    tick(); DBG_VALID = 1'b1; DBG_RD = 5'd0; DBG_DATA = 32'h44;
    @(negedge CLK);
    check_eq("x0_dbg_ready", DBG_READY, 1'b1);
    check_eq("x0_dbg_we3", WE3, 1'b0);
    check_eq("x0_dbg_wd3", WD3, 32'h44);
    tick(); DBG_VALID = 1'b0;

    // ---------------- set wins over same-cycle clear ----------------
    tick(); ISSUE_VALID = 1'b1; ISSUE_RD = 5'd7;
    LSU_VALID = 1'b1; LSU_RD = 5'd7; LSU_DATA = 32'h77;
    exp_q.push_back('{rd: 5'd7, data: 32'h77});
    tick(); LSU_VALID = 1'b0; RS1 = 5'd7;
    @(negedge CLK);
    check_eq("reissue_commit_a3", A3, 5'd7);
    tick(); ISSUE_VALID = 1'b0;
    @(negedge CLK);
    check_eq("busy7_set_wins", BUSY_RS1, 1'b1);
    check_eq("q_drained_x0", exp_q.size(), 0);

    // ---------------- asynchronous reset mid-stream ----------------
    tick(); ISSUE_VALID = 1'b1; ISSUE_RD = 5'd9;
    WB_VALID = 1'b1; WB_RD = 5'd2; WB_DATA = 32'hB2;
    LSU_VALID = 1'b1; LSU_RD = 5'd14; LSU_DATA = 32'hE0;
    tick(); ISSUE_VALID = 1'b0; LSU_RD = 5'd15; LSU_DATA = 32'hE1;
    tick(); LSU_VALID = 1'b0;
    #2 RSTn = 1'b0;
    #1;
    check_eq("async_rst_we3", WE3, 1'b0);
    check_eq("async_rst_a3", A3, '0);
    check_eq("async_rst_wd3", WD3, '0);
    check_eq("async_rst_lsu_ready", LSU_READY, 1'b0);
    idle_inputs();
    tick(); RSTn = 1'b1; RS1 = 5'd7; RS2 = 5'd9;
    @(negedge CLK);
    check_eq("post_rst_busy7", BUSY_RS1, 1'b0);
    check_eq("post_rst_busy9", BUSY_RS2, 1'b0);
    check_eq("post_rst_lsu_ready", LSU_READY, 1'b1);
    check_eq("post_rst_we3", WE3, 1'b0);
    tick();
    @(negedge CLK);
    check_eq("post_rst_fifo_empty_we3", WE3, 1'b0);
    check_eq("q_final", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rf_write_sched.md
Name: rf_write_sched

Overview:
- Write-port scheduler for the 32x32 integer register file, which has one write port (A3/WE3/WD3).
- Shares that port between three requesters:
  - pipeline writeback (WB): highest priority, cannot be stalled;
  - load/store unit late writeback (LSU): buffered in a small FIFO;
  - debug write port (DBG).
- Keeps a pending-load scoreboard so the hazard logic can stall readers of registers with an outstanding load.

Parameters:
- ADDRESS_WIDTH, 5, register address width; 2**ADDRESS_WIDTH registers.
- DATA_WIDTH, 32, register data width.
- LSU_FIFO_DEPTH, 2, LSU result buffer entries; power of two, >= 2.
- STARVE_LIMIT, 4, cycles DBG may wait before it outranks LSU; >= 1.

Ports:
- CLK  in  1  clock, rising edge.
- RSTn  in  1  reset, asynchronous, active-low.
- WB_VALID  in  1  pipeline writeback request; always granted.
- WB_RD  in  ADDRESS_WIDTH  writeback destination.
- WB_DATA  in  DATA_WIDTH  writeback data.
- ISSUE_VALID  in  1  load issued to LSU this cycle.
- ISSUE_RD  in  ADDRESS_WIDTH  destination of the issued load.
- LSU_VALID  in  1  LSU result valid.
- LSU_READY  out  1  FIFO can accept.
- LSU_RD  in  ADDRESS_WIDTH  LSU result destination.
- LSU_DATA  in  DATA_WIDTH  LSU result data.
- DBG_VALID  in  1  debug write request.
- DBG_READY  out  1  debug write granted this cycle.
- DBG_RD  in  ADDRESS_WIDTH  debug destination.
- DBG_DATA  in  DATA_WIDTH  debug data.
- RS1, RS2  in  ADDRESS_WIDTH  source registers to check.
- BUSY_RS1, BUSY_RS2  out  1  source has a pending load.
- A3  out  ADDRESS_WIDTH  to register file.
- WE3  out  1  to register file.
- WD3  out  DATA_WIDTH  to register file.

Behaviour:
- Reset (RSTn low, asynchronous):
  - FIFO empty; busy[] all 0; starve counter 0.
  - LSU_READY=0, DBG_READY=0, WE3=0, A3=0, WD3=0 while RSTn is low.
- Clock edges: all state changes on the CLK rising edge. A3/WE3/WD3 are combinational from the current-cycle winner; the register file commits on the same edge, giving zero added latency.
- Arbitration, one winner per cycle:
  - WB_VALID: WB wins.
  - Else if starved and DBG_VALID: DBG wins.
  - Else if FIFO non-empty: FIFO head wins.
  - Else if DBG_VALID: DBG wins.
  - Else idle (WE3=0).
- starved = (starve_cnt == STARVE_LIMIT).
- x0 suppression: if the winner's rd==0, WE3=0, but the grant, FIFO pop and handshake still complete. A3/WD3 still show the winner.
- LSU handshake:
  - LSU_READY = !full. It does not depend on a same-cycle pop, so a full FIFO refuses even while popping.
  - Enqueue when LSU_VALID && LSU_READY.
  - Pop when the FIFO head wins. Simultaneous push and pop is legal when not full.
  - Pointers are ADDRESS-independent, log2(depth)+1 bits, with wrap-around.
  - LSU results commit in arrival order.
- DBG handshake:
  - DBG_READY = DBG wins this cycle; transfer completes in that same cycle.
  - DBG_VALID must hold, and DBG_RD/DBG_DATA must stay stable, until DBG_READY.
- Starve counter:
  - On DBG_VALID && !DBG_READY: increment, saturating at STARVE_LIMIT.
  - On a DBG grant, or when DBG_VALID is low: clear to 0.
- Scoreboard, busy[2**ADDRESS_WIDTH]:
  - Set: ISSUE_VALID with ISSUE_RD != 0 sets busy[ISSUE_RD].
  - Clear: an LSU head commit clears busy[head.rd].
  - Same register set and cleared in one cycle: set wins (a new load is outstanding).
  - busy[0] is always 0.
  - WB and DBG writes do not touch busy.
- Busy queries: BUSY_RSx = busy[RSx], combinational. It is not bypassed; a clear takes effect the cycle after the commit.
- Starvation: DBG may be starved indefinitely by continuous WB_VALID; this is accepted, since WB is never stalled.
- Reset mid-operation: FIFO contents and pending bits are discarded; no write is issued.

Decomposition:
- Shared package rf_pkg:
  - parameter defaults;
  - typedef rf_addr_t;
  - typedef rf_data_t;
  - struct rf_wr_t {rd, data};
  - enum grant_e {GNT_NONE, GNT_WB, GNT_LSU, GNT_DBG}.
- One sub-module: sync_fifo, parameterised on width and depth, for the LSU buffer.
- Arbitration, starve counter and scoreboard stay in the top level.

Test Plan:
- Reset then idle → WE3=0, LSU_READY=1 after release, BUSY_RS1/RS2=0 for all RS.
- ISSUE_VALID rd=5; later LSU rd=5 data=0xDEADBEEF with WB idle → BUSY_RS1(5)=1 from the cycle after issue. A3=5, WE3=1, WD3=0xDEADBEEF in the cycle after enqueue. BUSY clears the following cycle.
- WB_VALID held for 4 cycles while 3 LSU results arrive, depth 2 → LSU_READY=0 on the third. After WB stops, FIFO entries commit in order on consecutive cycles. The third result then enqueues and commits.
- DBG_VALID rd=10 while FIFO is kept non-empty by continuous LSU traffic, STARVE_LIMIT=4 → DBG_READY=1 exactly 4 cycles after DBG_VALID rises. A3=10; starve counter returns to 0.
- LSU result rd=0, and DBG write rd=0 → handshakes complete, WE3=0, FIFO pops.
- ISSUE_RD=7 in the same cycle the LSU head commits rd=7 → busy[7]=1 afterwards. Assert RSTn low mid-stream → FIFO empty, busy cleared, WE3=0 immediately (asynchronous).
